// File: rtl/conv_tile_streamer_pkg.sv
// Shared dimensions and FSM state type for the convolution tile streamer.
package conv_pkg;
  localparam int unsigned TILE_DIM     = 6;
  localparam int unsigned K_DIM        = 3;
  localparam int unsigned OUT_DIM      = TILE_DIM - K_DIM + 1;
  localparam int unsigned KERNEL_BYTES = K_DIM * K_DIM;
  localparam int unsigned TILE_BYTES   = TILE_DIM * TILE_DIM;
  localparam int unsigned RESULT_WORDS = OUT_DIM * OUT_DIM;

  typedef enum logic [2:0] {
    ST_LOAD_K,
    ST_LOAD_T,
    ST_CLEAR,
    ST_START,
    ST_WAIT,
    ST_DRAIN
  } state_t;
endpackage

// File: rtl/conv_tile_streamer_if.sv
// Valid/ready stream with an optional end-of-packet marker.
interface conv_tile_streamer_if #(
  parameter int unsigned DW = 8
);
  logic          valid;
  logic          ready;
  logic          last;
  logic [DW-1:0] data;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/conv_result_serializer.sv
// Snapshots the engine result array and streams it row-major, flagging the final word.
module conv_result_serializer #(
  parameter int unsigned OUT_DIM = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_capture,
  input  logic [OUT_DIM-1:0][OUT_DIM-1:0][15:0] i_c,
  conv_tile_streamer_if.master                 m_bus,
  output logic                                 o_drain_done
);
  import conv_pkg::*;

  localparam int unsigned N  = OUT_DIM * OUT_DIM;
  localparam int unsigned IW = $clog2(N);

  logic [N*16-1:0] r_snap;
  logic [IW-1:0]   r_idx;
  logic            r_valid;
  logic            w_hs;
  logic            w_last;

  assign w_hs   = r_valid & m_bus.ready;
  assign w_last = (r_idx == IW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap  <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else if (i_capture) begin
      r_snap  <= i_c;
      r_idx   <= '0;
      r_valid <= 1'b1;
    end else if (w_hs) begin
      if (w_last) begin
        r_idx   <= '0;
        r_valid <= 1'b0;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // Flat offset (i*OUT_DIM+j)*16 is element c[i][j], so r_idx walks row-major.
  assign m_bus.valid  = r_valid;
  assign m_bus.data   = r_snap[r_idx*16 +: 16];
  assign m_bus.last   = r_valid & w_last;
  assign o_drain_done = w_hs & w_last;
endmodule

// File: rtl/conv_tile_streamer.sv
// Loads kernel and tile bytes for the 4x4 convolution engine, sequences it,
// and hands the captured results to the serializer.
module conv_tile_streamer #(
  parameter int unsigned TILE_DIM = 6,
  parameter int unsigned K_DIM    = 3
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic                                                 keep_kernel,
  conv_tile_streamer_if.slave                                  s_bus,
  output logic [TILE_DIM-1:0][TILE_DIM-1:0][7:0]               input_tile,
  output logic [K_DIM-1:0][K_DIM-1:0][7:0]                     kernel,
  output logic                                                 eng_clear,
  output logic                                                 start,
  input  logic                                                 done,
  input  logic [TILE_DIM-K_DIM:0][TILE_DIM-K_DIM:0][15:0]      c,
  conv_tile_streamer_if.master                                 m_bus,
  output logic                                                 busy
);
  import conv_pkg::*;

  localparam int unsigned OUT_D = TILE_DIM - K_DIM + 1;
  localparam int unsigned KB    = K_DIM * K_DIM;
  localparam int unsigned TB    = TILE_DIM * TILE_DIM;
  localparam int unsigned CW    = $clog2(TB);

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [KB*8-1:0] r_kernel;
  logic [TB*8-1:0] r_tile;
  logic            r_kvalid;
  logic            r_done_q;
  logic            w_s_hs;
  logic            w_skip_k;
  logic            w_done_rise;
  logic            w_capture;
  logic            w_drain_done;

  assign w_s_hs      = s_bus.valid & s_bus.ready;
  assign w_skip_k    = keep_kernel & r_kvalid;
  assign w_done_rise = done & ~r_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_LOAD_K;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    s_bus.ready = 1'b0;
    eng_clear   = 1'b0;
    start       = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_LOAD_K: begin
        s_bus.ready = 1'b1;
        if (w_s_hs && ((r_cnt == '0 && w_skip_k) || r_cnt == CW'(KB - 1)))
          w_next = ST_LOAD_T;
      end
      ST_LOAD_T: begin
        s_bus.ready = 1'b1;
        if (w_s_hs && r_cnt == CW'(TB - 1)) w_next = ST_CLEAR;
      end
      ST_CLEAR: begin
        eng_clear = 1'b1;
        w_next    = ST_START;
      end
      ST_START: begin
        start  = 1'b1;
        w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_done_rise) begin
          w_capture = 1'b1;
          w_next    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_drain_done) w_next = ST_LOAD_K;
      end
      default: w_next = ST_LOAD_K;
    endcase
  end

  // A reused kernel means the first byte of the frame is already tile[0][0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_kernel <= '0;
      r_tile   <= '0;
      r_kvalid <= 1'b0;
      r_done_q <= 1'b0;
    end else begin
      r_done_q <= done;
      if (w_s_hs && r_state == ST_LOAD_K) begin
        if (r_cnt == '0 && w_skip_k) begin
          r_tile[7:0] <= s_bus.data;
          r_cnt       <= CW'(1);
        end else begin
          r_kernel[r_cnt*8 +: 8] <= s_bus.data;
          if (r_cnt == CW'(KB - 1)) begin
            r_cnt    <= '0;
            r_kvalid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end else if (w_s_hs && r_state == ST_LOAD_T) begin
        r_tile[r_cnt*8 +: 8] <= s_bus.data;
        if (r_cnt == CW'(TB - 1)) r_cnt <= '0;
        else                      r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign kernel     = r_kernel;
  assign input_tile = r_tile;
  assign busy       = !(r_state == ST_LOAD_K && r_cnt == '0);

  conv_result_serializer #(
    .OUT_DIM (OUT_D)
  ) u_ser (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_capture    (w_capture),
    .i_c          (c),
    .m_bus        (m_bus),
    .o_drain_done (w_drain_done)
  );
endmodule

// File: tb/tb_conv_tile_streamer.sv
// Self-checking bench: engine model, byte-stream reference model, table and corner sequences.
module tb_conv_tile_streamer;
  logic clk = 1'b0;
  logic rst_n;
  logic keep_kernel;
  logic [5:0][5:0][7:0]  input_tile;
  logic [2:0][2:0][7:0]  kernel;
  logic                  eng_clear, start, done, busy;
  logic [3:0][3:0][15:0] c;

  conv_tile_streamer_if #(.DW(8))  s_bus ();
  conv_tile_streamer_if #(.DW(16)) m_bus ();

  conv_tile_streamer #(.TILE_DIM(6), .K_DIM(3)) dut (
    .clk(clk), .rst_n(rst_n), .keep_kernel(keep_kernel), .s_bus(s_bus),
    .input_tile(input_tile), .kernel(kernel), .eng_clear(eng_clear),
    .start(start), .done(done), .c(c), .m_bus(m_bus), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit gaps = 0;
  bit model_kv = 0;
  int ref_k [9];
  int ref_t [36];
  logic [16:0] got [$];

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Engine model: sticky done a few cycles after start, garbage results while cleared.
  bit eng_manual = 0;
  bit man_done = 0;
  logic eng_done = 0;
  int busy_cnt = 0;
  logic [3:0][3:0][15:0] c_r = '0;

  function automatic logic [15:0] conv_at(input logic [5:0][5:0][7:0] t,
                                          input logic [2:0][2:0][7:0] k, input int i, input int j);
    int s = 0;
    for (int m = 0; m < 3; m++)
      for (int n = 0; n < 3; n++) s += int'(k[m][n]) * int'(t[i+m][j+n]);
    return 16'(s);
  endfunction

  always @(posedge clk) begin
    if (eng_manual)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) c_r[i][j] <= conv_at(input_tile, kernel, i, j);
    if (eng_clear) begin
      eng_done <= 1'b0;
      busy_cnt <= 0;
      if (!eng_manual) c_r <= {16{16'hA5A5}};
    end else if (start) begin
      busy_cnt <= 3 + int'($urandom_range(5, 0));
    end else if (busy_cnt == 1) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) c_r[i][j] <= conv_at(input_tile, kernel, i, j);
      eng_done <= 1'b1;
      busy_cnt <= 0;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end
  assign done = eng_manual ? man_done : eng_done;
  assign c = c_r;

  always @(posedge clk) begin
    #1 m_bus.ready = gaps ? 1'($urandom_range(1, 0)) : 1'b1;
  end

  // Expected result word k from the bytes sent (row-major over the 4x4 output).
  function automatic logic [15:0] exp_word(input int k);
    int i = k / 4, j = k % 4, s = 0;
    for (int m = 0; m < 3; m++)
      for (int n = 0; n < 3; n++) s += ref_k[m*3+n] * ref_t[(i+m)*6 + j + n];
    return 16'(s);
  endfunction

  task automatic monitor();
    int cyc = 0, last_s = -10, clear_cyc = -10, exp_mv = -1;
    bit waiting = 0, p_clear = 0, p_start = 0, p_done = 0, p_mv = 0, p_mr = 0, p_last = 0;
    logic [15:0] p_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        waiting = 0; exp_mv = -1; last_s = -10; clear_cyc = -10;
        p_clear = 0; p_start = 0; p_done = 0; p_mv = 0; p_mr = 0;
      end else begin
        if (s_bus.valid && s_bus.ready) last_s = cyc;
        if (eng_clear) begin
          check(cyc == last_s + 1 && !p_clear, "clear_timing", cyc - last_s, 1);
          clear_cyc = cyc;
        end
        if (start) begin
          check(cyc == clear_cyc + 1 && !p_start, "start_timing", cyc - clear_cyc, 1);
          waiting = 1;
        end
        if (waiting && m_bus.valid) check(1'b0, "valid_before_done_edge", 1, 0);
        if (waiting && done && !p_done) begin
          waiting = 0;
          exp_mv = cyc + 1;
        end
        if (cyc == exp_mv) begin
          check(m_bus.valid, "valid_latency", int'(m_bus.valid), 1);
          exp_mv = -1;
        end
        if (p_mv && !p_mr)
          check(m_bus.valid && m_bus.data == p_data && m_bus.last == p_last,
                "stall_hold", int'(m_bus.data), int'(p_data));
        if (m_bus.valid && m_bus.ready) got.push_back({m_bus.last, m_bus.data});
        p_clear = eng_clear; p_start = start; p_done = done;
        p_mv = m_bus.valid; p_mr = m_bus.ready; p_data = m_bus.data; p_last = m_bus.last;
      end
    end
  endtask

  task automatic load_frame(input bit keep, input bit rnd, input int kval, input int toff,
                            input int exp_bytes, input bit chk);
    logic [7:0] q [$];
    logic [2:0][2:0][7:0] ek;
    logic [5:0][5:0][7:0] et;
    bit needk = !(keep && model_kv);
    bit stop = 0;
    int consumed = 0;
    if (needk) begin
      for (int i = 0; i < 9; i++) begin
        ref_k[i] = rnd ? int'($urandom_range(255, 0)) : kval;
        q.push_back(8'(ref_k[i]));
      end
      model_kv = 1;
    end
    for (int i = 0; i < 36; i++) begin
      ref_t[i] = rnd ? int'($urandom_range(255, 0)) : i + toff;
      q.push_back(8'(ref_t[i]));
    end
    keep_kernel = keep;
    foreach (q[i]) begin
      if (!stop) begin
        if (gaps)
          while ($urandom_range(1, 0) == 1) begin
            s_bus.valid = 1'b0;
            @(posedge clk); #1;
          end
        s_bus.valid = 1'b1;
        s_bus.data  = q[i];
        @(negedge clk);
        if (!s_bus.ready) stop = 1;
        else begin
          @(posedge clk); #1;
          consumed++;
          keep_kernel = gaps ? 1'($urandom_range(1, 0)) : 1'b0;
        end
      end
    end
    s_bus.valid = 1'b0;
    check(consumed == (chk ? exp_bytes : q.size()), "bytes_consumed", consumed,
          chk ? exp_bytes : q.size());
    @(negedge clk);
    check(!s_bus.ready, "left_load_states", int'(s_bus.ready), 0);
    for (int m = 0; m < 3; m++) for (int n = 0; n < 3; n++) ek[m][n] = 8'(ref_k[m*3+n]);
    for (int r = 0; r < 6; r++) for (int p = 0; p < 6; p++) et[r][p] = 8'(ref_t[r*6+p]);
    check(kernel == ek, "kernel_array", int'(kernel[0][0]), int'(ek[0][0]));
    check(input_tile == et, "tile_array", int'(input_tile[0][0]), int'(et[0][0]));
  endtask

  task automatic finish_frame(input bit chk, input int exp00, input int exp33);
    int n = 0;
    while (got.size() < 16 && n < 4000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(got.size() == 16, "word_count", got.size(), 16);
    for (int k = 0; k < 16; k++) begin
      if (k < got.size()) begin
        check(got[k][15:0] == exp_word(k), "word", int'(got[k][15:0]), int'(exp_word(k)));
        check(got[k][16] == (k == 15), "last_flag", int'(got[k][16]), int'(k == 15));
      end
    end
    if (chk && got.size() == 16) begin
      check(got[0][15:0] == 16'(exp00), "c00_const", int'(got[0][15:0]), exp00);
      check(got[15][15:0] == 16'(exp33), "c33_const", int'(got[15][15:0]), exp33);
    end
    check(!busy && s_bus.ready, "idle_after_drain", int'(busy), 0);
    got.delete();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_kv = 0;
    got.delete();
  endtask

  typedef struct {
    bit keep;
    int kval;
    int toff;
    int exp_bytes;
    int exp00;
    int exp33;
  } vec_t;
  vec_t tbl [4];

  initial begin
    // Kernel all kval, tile[r][q] = 6r+q+toff: c[i][j] = 9*kval*(6i+j+7+toff).
    tbl[0] = '{keep: 0, kval: 1, toff: 0,  exp_bytes: 45, exp00: 63,  exp33: 252};
    tbl[1] = '{keep: 1, kval: 9, toff: 10, exp_bytes: 36, exp00: 153, exp33: 342};
    tbl[2] = '{keep: 0, kval: 2, toff: 0,  exp_bytes: 45, exp00: 126, exp33: 504};
    tbl[3] = '{keep: 1, kval: 7, toff: 3,  exp_bytes: 36, exp00: 180, exp33: 558};

    rst_n = 1'b0; keep_kernel = 1'b0;
    s_bus.valid = 1'b0; s_bus.data = '0; s_bus.last = 1'b0;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check(s_bus.ready == 1'b1, "rst_s_ready", int'(s_bus.ready), 1);
    check(!m_bus.valid && !m_bus.last && m_bus.data == '0, "rst_m_side", int'(m_bus.valid), 0);
    check(!start && !eng_clear && !busy, "rst_pulses_busy", int'(busy), 0);
    check(kernel == '0 && input_tile == '0, "rst_arrays", int'(kernel[0][0]), 0);

    for (int i = 0; i < 4; i++) begin
      load_frame(tbl[i].keep, 1'b0, tbl[i].kval, tbl[i].toff, tbl[i].exp_bytes, 1'b1);
      finish_frame(1'b1, tbl[i].exp00, tbl[i].exp33);
    end

    // keep_kernel with no kernel since reset: all 45 bytes taken.
    apply_reset();
    load_frame(1'b1, 1'b0, 1, 0, 45, 1'b1);
    finish_frame(1'b1, 63, 252);

    gaps = 1;
    for (int f = 0; f < 8; f++) begin
      load_frame(1'($urandom_range(1, 0)), 1'b1, 0, 0, 0, 1'b0);
      finish_frame(1'b0, 0, 0);
    end

    // done already high on WAIT entry: only a later rising edge releases results.
    eng_manual = 1; man_done = 1;
    load_frame(1'b0, 1'b1, 0, 0, 0, 1'b0);
    repeat (30) @(posedge clk);
    #1 check(!m_bus.valid && got.size() == 0, "no_edge_no_output", got.size(), 0);
    man_done = 0;
    repeat (2) @(posedge clk);
    #1 man_done = 1;
    finish_frame(1'b0, 0, 0);
    eng_manual = 0;

    // Reset while word 7 is on the output.
    load_frame(1'b0, 1'b1, 0, 0, 0, 1'b0);
    begin
      int n = 0;
      while (got.size() < 7 && n < 4000) begin
        @(negedge clk);
        n++;
      end
    end
    check(got.size() == 7, "reached_word7", got.size(), 7);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check(!m_bus.valid && !m_bus.last, "mid_drain_rst_valid", int'(m_bus.valid), 0);
    check(s_bus.ready && !busy, "mid_drain_rst_ready", int'(s_bus.ready), 1);
    check(kernel == '0 && input_tile == '0, "mid_drain_rst_arrays", int'(kernel[0][0]), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_kv = 0;
    got.delete();
    gaps = 0;
    load_frame(1'b1, 1'b0, 2, 0, 45, 1'b1);
    finish_frame(1'b1, 126, 504);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conv_tile_streamer.md
# conv_tile_streamer

Front-end and back-end for the 4x4 convolution engine. Accepts a byte stream carrying a 3x3 kernel and a 6x6 input tile, and holds them as stable register arrays driving the engine. It then clears and starts the engine and waits for completion. Finally it snapshots the 4x4 16-bit result array and streams it out over a valid/ready interface. It sits between the host DMA byte stream and the engine.

## Interface
- TILE_DIM, 6, input tile edge
- K_DIM, 3, kernel edge
- OUT_DIM, TILE_DIM-K_DIM+1 (4), result edge; not overridable independently
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- keep_kernel  in  1  sampled with first accepted byte of a frame; 1 = skip kernel phase, reuse held kernel
- s_valid  in  1  input byte valid
- s_ready  out  1  input byte accepted when s_valid & s_ready
- s_data  in  8  unsigned byte, kernel row-major then tile row-major
- input_tile  out  8 x [TILE_DIM][TILE_DIM]  to engine, stable from CLEAR through WAIT
- kernel  out  8 x [K_DIM][K_DIM]  to engine
- eng_clear  out  1  one-cycle pulse clearing engine state and its sticky done
- start  out  1  one-cycle pulse to engine
- done  in  1  engine completion, level (sticky until cleared)
- c  in  16 x [OUT_DIM][OUT_DIM]  engine results, valid when done rises
- m_valid  out  1  result word valid
- m_ready  in  1  result word accepted when m_valid & m_ready
- m_data  out  16  result word, row-major c[i][j]
- m_last  out  1  high with the 16th word
- busy  out  1  high in every state except LOAD_K/LOAD_T before first byte

## Operation
- States: LOAD_K, LOAD_T, CLEAR, START, WAIT, DRAIN. Reset state LOAD_K.
- Frame start: in LOAD_K with byte counter 0, first handshake samples keep_kernel. If it is 1 and the kernel is valid (loaded since reset), that byte is tile[0][0] and the FSM goes to LOAD_T. Otherwise it is kernel[0][0]. keep_kernel=1 with no valid kernel is treated as 0.
- LOAD_K: 9 bytes into kernel[m][n], n fastest; after 9th -> LOAD_T, set kernel-valid.
- LOAD_T: 36 bytes into input_tile[r][q], q fastest; after 36th -> CLEAR.
- CLEAR: eng_clear=1 for 1 cycle -> START.
- START: start=1 for 1 cycle -> WAIT.
- WAIT: leave on done rising edge (done & ~done_q, done_q registered). Capture all 16 c words into snapshot register on that edge -> DRAIN.
- DRAIN: present snapshot[k], k=0..15 row-major; advance on handshake; m_last when k=15; after last handshake -> LOAD_K, counter 0.
- s_ready=1 only in LOAD_K/LOAD_T; input_tile/kernel never change outside those states.
- No arithmetic; results passed through unmodified, full 16 bits.

## Timing
- Reset values: s_ready=1, m_valid=0, m_last=0, m_data=0, start=0, eng_clear=0, busy=0, input_tile/kernel/snapshot all 0, kernel-valid=0. Reset mid-frame or mid-drain discards everything; no partial output.
- Throughput: one input byte per cycle under continuous s_valid; s_valid gaps stall without loss.
- 36th tile byte accepted at cycle T: eng_clear at T+1, start at T+2, WAIT from T+3.
- Done edge at cycle D: m_valid=1 from D+1; one word per cycle under continuous m_ready; m_ready low holds m_data/m_last stable.
- done already high on WAIT entry (engine not cleared) is not an edge: FSM waits, no output.
- m_valid never drops without a handshake.

## Structure
- Package conv_pkg: TILE_DIM, K_DIM, OUT_DIM, KERNEL_BYTES=9, TILE_BYTES=36, RESULT_WORDS=16, state enum type.
- One sub-module: conv_result_serializer (snapshot register + 16-word valid/ready output with m_last); the loader FSM stays in the top.

## Test plan
- Reset, stream kernel all 1, tile bytes 0..35 -> after done edge, 16 words equal engine model sums, m_last only on 16th, eng_clear/start each one cycle, in order.
- Second frame with keep_kernel=1, 36 tile bytes -> kernel unchanged, result uses first kernel.
- keep_kernel=1 on first frame after reset -> first byte loaded as kernel[0][0]; 45 bytes consumed.
- Random s_valid and m_ready gaps (50%) -> identical output sequence, m_data stable while stalled.
- done held high throughout WAIT with no rising edge -> no m_valid until done falls and rises.
- rst_n asserted during DRAIN at word 7 -> m_valid=0 immediately, s_ready=1, arrays 0; next frame correct.
